aes_sbox_composite_field: RTL and testbench
===========================================

Name: aes_sbox_composite_field

Overview:
Single-byte AES SubBytes / InvSubBytes unit, forward or inverse selected per input by enc_dec. Multiplicative inversion uses composite-field GF((2^4)^2) arithmetic; no 256-entry lookup table is allowed. Registered output, one byte per clock. Instantiated 16x (state) and 4x (key schedule) by the AES round datapath.

Parameters:
None. Widths are fixed at 8 bits.

Ports:
clk        input   1  system clock, rising edge
rst_n      input   1  asynchronous active-low reset
in_valid   input   1  data_in/enc_dec qualified this cycle
data_in    input   8  input byte
enc_dec    input   1  1 = forward S-box (encrypt), 0 = inverse S-box (decrypt)
out_valid  output  1  data_out holds a new result
data_out   output  8  substituted byte

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous): data_out=8'h00, out_valid=0 immediately. Both are held until the first rising clk edge after release.
- Forward (enc_dec=1): data_out = A(inv(x)).
  - inv = GF(2^8) inverse modulo x^8+x^4+x^3+x+1, with inv(0)=0.
  - A is the affine map b_i = x_i ^ x_(i+4) ^ x_(i+5) ^ x_(i+6) ^ x_(i+7) ^ c_i. Indices are mod 8; c = 8'h63.
- Inverse (enc_dec=0): data_out = inv(A^-1(x)).
  - A^-1 is b_i = x_(i+2) ^ x_(i+5) ^ x_(i+7) ^ d_i, with d = 8'h05.
- Inversion datapath:
  - Map the byte into GF((2^4)^2) using the isomorphism matrix.
  - Ground field GF(2^4) uses poly x^4+x+1; extension uses y^2+y+lambda with lambda=4'hC.
  - Invert: square, scale by lambda, multiply, 4-bit inversion, two multiplies.
  - Map back with the inverse isomorphism.
  - Any isomorphism is acceptable, provided the results are bit-exact to FIPS-197 for all 256 inputs in both directions.
- The affine/inverse-affine selection muxes before and after the shared inverter, so forward and inverse share one inverter.
- Latency: 1 clock. A result is registered on the rising edge where in_valid=1. On that edge out_valid<=1, and data_out updates to the function of the sampled data_in/enc_dec.
- When in_valid=0 at an edge: out_valid<=0 and data_out holds its previous value.
- Throughput: 1 byte/cycle. enc_dec may change every cycle with no bubble.
- Back-to-back with in_valid high: each cycle's output corresponds solely to the previous cycle's inputs. There is no state besides the output registers.
- Reset asserted mid-stream: outputs clear at once. In-flight data is discarded.
- X on data_in while in_valid=0 must not propagate to data_out.

Optional Feature:
AES_SBOX_PIPE_EN:
- Defined: adds an internal pipeline register after the GF(2^4) inversion stage, also reset asynchronously to 0.
  - Latency becomes 2 clocks. out_valid tracks in_valid delayed 2 cycles.
  - Throughput stays 1/cycle. enc_dec is pipelined alongside the data.
- Undefined: single-stage behaviour as described above, latency 1.

Test Plan:
- Reset: assert rst_n=0 mid-operation, with no clk edge -> data_out=00 and out_valid=0 immediately. First valid input after release -> correct result after the configured latency.
- Forward spot values, enc_dec=1:
  - 00->63, 01->7c, 10->ca, 2f->15
  - 53->ed, ff->16, aa->ac
  - out_valid=1 exactly latency cycles after in_valid.
- Inverse spot values, enc_dec=0: 63->00, 7c->01, ed->53, 16->ff, ac->aa.
- Exhaustive: all 256 inputs in both modes against the FIPS-197 tables. Round trip: inverse(forward(x))==x for x=00..ff.
- Streaming: in_valid held high, enc_dec toggling every cycle, input sequence 00,63,53,ed -> outputs 63,00,ed,53 on consecutive cycles.
- Hold: drop in_valid for 3 cycles with data_in changing -> out_valid=0 and data_out unchanged from the last result.

Source files
------------

// File: rtl/aes_sbox_composite_field.sv
// AES SubBytes / InvSubBytes byte unit. A single GF((2^4)^2) inverter is shared by both directions.
// Define AES_SBOX_PIPE_EN to add a register after the GF(2^4) inversion, which gives a latency of 2.
module aes_sbox_composite_field (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] data_in,
    input  logic       enc_dec,
    output logic       out_valid,
    output logic [7:0] data_out
);

    localparam logic [3:0] LAMBDA = 4'hC;

    // Ground field GF(2^4), polynomial x^4 + x + 1
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] acc;
        logic [3:0] sh;
        acc = 4'h0;
        sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1: r = 4'h1;
            4'h2: r = 4'h9;
            4'h3: r = 4'hE;
            4'h4: r = 4'hD;
            4'h5: r = 4'hB;
            4'h6: r = 4'h7;
            4'h7: r = 4'h6;
            4'h8: r = 4'hF;
            4'h9: r = 4'h2;
            4'hA: r = 4'hC;
            4'hB: r = 4'h5;
            4'hC: r = 4'hA;
            4'hD: r = 4'h4;
            4'hE: r = 4'h3;
            4'hF: r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // Isomorphism sends the AES generator x to 8'h21, a root of x^8+x^4+x^3+x+1 in the composite field
    function automatic logic [7:0] map_to_composite(input logic [7:0] x);
        logic [7:0] q;
        q[0] = x[0] ^ x[1];
        q[1] = x[3] ^ x[5] ^ x[7];
        q[2] = x[2] ^ x[3] ^ x[4] ^ x[6];
        q[3] = x[3] ^ x[5] ^ x[6];
        q[4] = x[4] ^ x[5] ^ x[6];
        q[5] = x[1] ^ x[4] ^ x[6] ^ x[7];
        q[6] = x[2] ^ x[3] ^ x[5] ^ x[7];
        q[7] = x[5] ^ x[7];
        return q;
    endfunction

    function automatic logic [7:0] map_from_composite(input logic [7:0] q);
        logic [7:0] x;
        x[0] = q[0] ^ q[4] ^ q[5] ^ q[7];
        x[1] = q[4] ^ q[5] ^ q[7];
        x[2] = q[1] ^ q[6];
        x[3] = q[1] ^ q[7];
        x[4] = q[1] ^ q[3] ^ q[4] ^ q[7];
        x[5] = q[2] ^ q[4] ^ q[6] ^ q[7];
        x[6] = q[1] ^ q[2] ^ q[3] ^ q[4] ^ q[6];
        x[7] = q[2] ^ q[4] ^ q[6];
        return x;
    endfunction

    function automatic logic [7:0] affine_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] sel_byte;
    logic [7:0] comp_s1;
    logic [3:0] hi_s1;
    logic [3:0] lo_s1;
    logic [3:0] delta_s1;
    logic [3:0] dinv_s1;

    logic [3:0] hi_s2;
    logic [3:0] sum_s2;
    logic [3:0] dinv_s2;
    logic       enc_s2;
    logic       valid_s2;

    logic [7:0] inv_byte;
    logic [7:0] result;
    logic       out_valid_d;
    logic       out_valid_q;
    logic [7:0] data_out_d;
    logic [7:0] data_out_q;

    // Norm of (hi*y + lo) for y^2 + y + lambda: lambda*hi^2 + lo*(hi + lo)
    always_comb begin
        sel_byte = enc_dec ? data_in : affine_inv(data_in);
        comp_s1  = map_to_composite(sel_byte);
        hi_s1    = comp_s1[7:4];
        lo_s1    = comp_s1[3:0];
        delta_s1 = gf16_mul(gf16_mul(hi_s1, hi_s1), LAMBDA) ^ gf16_mul(hi_s1 ^ lo_s1, lo_s1);
        dinv_s1  = gf16_inv(delta_s1);
    end

`ifdef AES_SBOX_PIPE_EN
    logic [3:0] hi_d, hi_q;
    logic [3:0] sum_d, sum_q;
    logic [3:0] dinv_d, dinv_q;
    logic       enc_d, enc_q;
    logic       pipe_valid_d, pipe_valid_q;

    // Stage data only loads on valid input, so idle-cycle inputs never reach the output
    always_comb begin
        pipe_valid_d = in_valid;
        hi_d         = hi_q;
        sum_d        = sum_q;
        dinv_d       = dinv_q;
        enc_d        = enc_q;
        if (in_valid) begin
            hi_d   = hi_s1;
            sum_d  = hi_s1 ^ lo_s1;
            dinv_d = dinv_s1;
            enc_d  = enc_dec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q         <= 4'h0;
            sum_q        <= 4'h0;
            dinv_q       <= 4'h0;
            enc_q        <= 1'b0;
            pipe_valid_q <= 1'b0;
        end else begin
            hi_q         <= hi_d;
            sum_q        <= sum_d;
            dinv_q       <= dinv_d;
            enc_q        <= enc_d;
            pipe_valid_q <= pipe_valid_d;
        end
    end

    assign hi_s2    = hi_q;
    assign sum_s2   = sum_q;
    assign dinv_s2  = dinv_q;
    assign enc_s2   = enc_q;
    assign valid_s2 = pipe_valid_q;
`else
    assign hi_s2    = hi_s1;
    assign sum_s2   = hi_s1 ^ lo_s1;
    assign dinv_s2  = dinv_s1;
    assign enc_s2   = enc_dec;
    assign valid_s2 = in_valid;
`endif

    // Inverse is (hi*d^-1)*y + (hi+lo)*d^-1
    always_comb begin
        inv_byte    = map_from_composite({gf16_mul(hi_s2, dinv_s2), gf16_mul(sum_s2, dinv_s2)});
        result      = enc_s2 ? affine_fwd(inv_byte) : inv_byte;
        out_valid_d = valid_s2;
        data_out_d  = valid_s2 ? result : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;

endmodule

// File: tb/tb_aes_sbox_composite_field.sv
// Testbench for aes_sbox_composite_field: spot-value table, exhaustive and randomized streams
// against a brute-force GF(2^8) reference model, plus reset and hold sequences.
module tb_aes_sbox_composite_field;

`ifdef AES_SBOX_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] data_in;
    logic       enc_dec;
    logic       out_valid;
    logic [7:0] data_out;

    int testsRun  = 0;
    int failCount = 0;

    logic       pipeV [LAT];
    logic [7:0] pipeD [LAT];
    logic       expValid;
    logic [7:0] expData;

    typedef struct {
        logic [7:0] din;
        logic       enc;
        logic [7:0] dout;
    } spot_t;

    spot_t spots [12];

    always #5 clk = ~clk;

    aes_sbox_composite_field dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .enc_dec   (enc_dec),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    // Reference model: schoolbook polynomial multiply mod x^8+x^4+x^3+x+1, inverse by search
    function automatic logic [7:0] refMul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011B << (k - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] refInv(input logic [7:0] a);
        if (a == 8'h00) return 8'h00;
        for (int y = 1; y < 256; y++)
            if (refMul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    function automatic logic [7:0] refAffineFwd(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            b[i] = x[i] ^ x[(i + 4) % 8] ^ x[(i + 5) % 8] ^ x[(i + 6) % 8] ^ x[(i + 7) % 8] ^ c[i];
        return b;
    endfunction

    function automatic logic [7:0] refAffineInv(input logic [7:0] x);
        logic [7:0] b;
        logic [7:0] d;
        d = 8'h05;
        for (int i = 0; i < 8; i++)
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ d[i];
        return b;
    endfunction

    function automatic logic [7:0] refSbox(input logic [7:0] x, input logic enc);
        return enc ? refAffineFwd(refInv(x)) : refInv(refAffineInv(x));
    endfunction

    task automatic clearModel();
        for (int i = 0; i < LAT; i++) begin
            pipeV[i] = 1'b0;
            pipeD[i] = 8'h00;
        end
        expValid = 1'b0;
        expData  = 8'h00;
    endtask

    task automatic checkOutput(input string name);
        testsRun++;
        if (out_valid !== expValid) begin
            failCount++;
            $display("[TB] FAIL %s: out_valid=%0b expected %0b", name, out_valid, expValid);
        end
        testsRun++;
        if (data_out !== expData) begin
            failCount++;
            $display("[TB] FAIL %s: data_out=%02h expected %02h", name, data_out, expData);
        end
    endtask

    // Drive one cycle at a negedge, advance the delay-line model at the posedge, check at the next negedge
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                                 input logic [7:0] exp, input string name);
        in_valid = v;
        data_in  = d;
        enc_dec  = e;
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) begin
            pipeV[i] = pipeV[i - 1];
            pipeD[i] = pipeD[i - 1];
        end
        pipeV[0] = v;
        pipeD[0] = exp;
        expValid = pipeV[LAT - 1];
        if (expValid) expData = pipeD[LAT - 1];
        @(negedge clk);
        checkOutput(name);
    endtask

    task automatic drain();
        for (int i = 0; i < LAT; i++)
            applyStimulus(1'b0, 8'(i * 37), 1'b1, 8'h00, "drain");
    endtask

    initial begin
        logic [7:0] x;
        logic       v;
        logic       e;

        spots[0]  = '{8'h00, 1'b1, 8'h63};
        spots[1]  = '{8'h01, 1'b1, 8'h7c};
        spots[2]  = '{8'h10, 1'b1, 8'hca};
        spots[3]  = '{8'h2f, 1'b1, 8'h15};
        spots[4]  = '{8'h53, 1'b1, 8'hed};
        spots[5]  = '{8'hff, 1'b1, 8'h16};
        spots[6]  = '{8'haa, 1'b1, 8'hac};
        spots[7]  = '{8'h63, 1'b0, 8'h00};
        spots[8]  = '{8'h7c, 1'b0, 8'h01};
        spots[9]  = '{8'hed, 1'b0, 8'h53};
        spots[10] = '{8'h16, 1'b0, 8'hff};
        spots[11] = '{8'hac, 1'b0, 8'haa};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        data_in  = 8'h00;
        enc_dec  = 1'b0;
        clearModel();
        repeat (2) @(negedge clk);
        checkOutput("reset_state");
        rst_n = 1'b1;

        foreach (spots[i])
            applyStimulus(1'b1, spots[i].din, spots[i].enc, spots[i].dout,
                          $sformatf("spot_%02h_%0b", spots[i].din, spots[i].enc));
        drain();

        applyStimulus(1'b1, 8'h00, 1'b1, 8'h63, "stream_0");
        applyStimulus(1'b1, 8'h63, 1'b0, 8'h00, "stream_1");
        applyStimulus(1'b1, 8'h53, 1'b1, 8'hed, "stream_2");
        applyStimulus(1'b1, 8'hed, 1'b0, 8'h53, "stream_3");

        for (int k = 0; k < 3; k++)
            applyStimulus(1'b0, 8'(8'h3c + k * 8'h51), k[0], 8'h00, "hold");
        applyStimulus(1'b0, 8'bxxxx_xxxx, 1'b1, 8'h00, "hold_x");
        drain();

        for (int i = 0; i < 256; i++)
            applyStimulus(1'b1, 8'(i), 1'b1, refSbox(8'(i), 1'b1), $sformatf("fwd_%02h", i));
        drain();

        for (int i = 0; i < 256; i++)
            applyStimulus(1'b1, refSbox(8'(i), 1'b1), 1'b0, 8'(i), $sformatf("roundtrip_%02h", i));
        drain();

        for (int i = 0; i < 300; i++) begin
            x = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            e = 1'($urandom);
            applyStimulus(v, x, e, refSbox(x, e), "random");
        end
        drain();

        applyStimulus(1'b1, 8'h2f, 1'b1, 8'h15, "pre_reset_0");
        applyStimulus(1'b1, 8'h16, 1'b0, 8'hff, "pre_reset_1");
        in_valid = 1'b1;
        data_in  = 8'haa;
        enc_dec  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("async_reset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_held");
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h53, 1'b1, 8'hed, "post_reset");
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
